// File: rtl/memgame_pkg.sv
`default_nettype none
// ============================================================================
// Package : memgame_pkg
// Shared types and constants for the 16-card memory game controller.
// Rev     : 1.0
// ============================================================================
package memgame_pkg;

   localparam int N_CARDS_C = 16;
   localparam int LABEL_W_C = 4;
   localparam int SCORE_W_C = 4;

   typedef enum logic [2:0] {
      PICK1 = 3'd0,
      PICK2 = 3'd1,
      SHOW  = 3'd2,
      JUDGE = 3'd3,
      OVER  = 3'd4
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P0   = 2'b01;
   localparam logic [1:0] WIN_P1   = 2'b10;
   localparam logic [1:0] WIN_TIE  = 2'b11;

   function automatic logic [1:0] decide_winner(
      input logic [SCORE_W_C-1:0] s0,
      input logic [SCORE_W_C-1:0] s1
   );
      if (s0 > s1) return WIN_P0;
      if (s1 > s0) return WIN_P1;
      return WIN_TIE;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pair_judge_if.sv
`default_nettype none
// ============================================================================
// Interface : pair_judge_if
// Select inputs and game-state outputs of the pair_judge controller.
// Rev       : 1.0
// ============================================================================
interface pair_judge_if
   import memgame_pkg::*;
#(
   parameter int N_CARDS = N_CARDS_C,
   parameter int LABEL_W = LABEL_W_C
);
   localparam int IDX_W = $clog2(N_CARDS);

   logic                 select;
   logic [IDX_W-1:0]     cursor;
   logic [LABEL_W-1:0]   label;
   logic [N_CARDS-1:0]   revealed;
   logic [N_CARDS-1:0]   taken;
   logic                 player;
   logic [SCORE_W_C-1:0] score0;
   logic [SCORE_W_C-1:0] score1;
   logic                 timeout;
   logic                 busy;
   logic                 game_over;
   logic [1:0]           winner;

   modport master (
      output select, cursor, label,
      input  revealed, taken, player, score0, score1,
      input  timeout, busy, game_over, winner
   );

   modport slave (
      input  select, cursor, label,
      output revealed, taken, player, score0, score1,
      output timeout, busy, game_over, winner
   );

endinterface
`default_nettype wire

// File: rtl/turn_timer.sv
`default_nettype none
// ============================================================================
// Module : turn_timer
// Loadable down-counter with enable and an expire flag.
// Rev    : 1.0
// ============================================================================
module turn_timer #(
   parameter int LOAD_VAL = 16
)(
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_en,
   output logic o_expire
);
   localparam int            W      = $clog2(LOAD_VAL) + 1;
   localparam logic [W-1:0]  c_LOAD = W'(LOAD_VAL);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= c_LOAD;
      end else if (i_load) begin
         r_cnt <= c_LOAD;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   // Raised in the enabled cycle whose decrement reaches zero, so the owner reacts on that edge.
   assign o_expire = i_en && (r_cnt <= W'(1));

endmodule
`default_nettype wire

// File: rtl/pair_judge.sv
`default_nettype none
// ============================================================================
// Module : pair_judge
// Turn/match controller: reveal two cards, judge, score, timeout, winner.
// Rev    : 1.0
// ============================================================================
module pair_judge
   import memgame_pkg::*;
#(
   parameter int N_CARDS     = N_CARDS_C,
   parameter int LABEL_W     = LABEL_W_C,
   parameter int SHOW_CYC    = 50_000_000,
   parameter int TIMEOUT_CYC = 750_000_000
)(
   input  logic        clk,
   input  logic        rst,
   pair_judge_if.slave bus
);
   localparam int                 IDX_W = $clog2(N_CARDS);
   localparam logic [N_CARDS-1:0] c_ONE = {{(N_CARDS-1){1'b0}}, 1'b1};

   state_t               r_state;
   state_t               w_state_nxt;

   logic [IDX_W-1:0]     r_idx1;
   logic [IDX_W-1:0]     r_idx2;
   logic [LABEL_W-1:0]   r_lab1;
   logic [LABEL_W-1:0]   r_lab2;
   logic [N_CARDS-1:0]   r_revealed;
   logic [N_CARDS-1:0]   r_taken;
   logic                 r_player;
   logic [SCORE_W_C-1:0] r_score0;
   logic [SCORE_W_C-1:0] r_score1;
   logic                 r_timeout;

   logic                 w_sel_ok;
   logic                 w_match;
   logic [N_CARDS-1:0]   w_taken_judged;
   logic                 w_accept1;
   logic                 w_accept2;
   logic                 w_expire_turn;
   logic                 w_judge;
   logic                 w_turn_load;
   logic                 w_turn_en;
   logic                 w_turn_exp;
   logic                 w_show_load;
   logic                 w_show_en;
   logic                 w_show_exp;

   turn_timer #(.LOAD_VAL(TIMEOUT_CYC)) u_turn_tmr (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_turn_load),
      .i_en     (w_turn_en),
      .o_expire (w_turn_exp)
   );

   turn_timer #(.LOAD_VAL(SHOW_CYC)) u_show_tmr (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_show_load),
      .i_en     (w_show_en),
      .o_expire (w_show_exp)
   );

   assign w_sel_ok       = bus.select && !r_taken[bus.cursor] && !r_revealed[bus.cursor];
   assign w_match        = (r_lab1 == r_lab2);
   assign w_taken_judged = w_match ? (r_taken | (c_ONE << r_idx1) | (c_ONE << r_idx2)) : r_taken;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= PICK1;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A valid select outranks a simultaneous turn expiry in both pick states.
   always_comb begin
      w_state_nxt   = r_state;
      w_accept1     = 1'b0;
      w_accept2     = 1'b0;
      w_expire_turn = 1'b0;
      w_judge       = 1'b0;
      w_turn_load   = 1'b0;
      w_turn_en     = 1'b0;
      w_show_load   = 1'b0;
      w_show_en     = 1'b0;
      case (r_state)
         PICK1: begin
            w_turn_en = 1'b1;
            if (w_sel_ok) begin
               w_accept1   = 1'b1;
               w_turn_load = 1'b1;
               w_state_nxt = PICK2;
            end else if (w_turn_exp) begin
               w_expire_turn = 1'b1;
               w_turn_load   = 1'b1;
            end
         end
         PICK2: begin
            w_turn_en = 1'b1;
            if (w_sel_ok) begin
               w_accept2   = 1'b1;
               w_show_load = 1'b1;
               w_state_nxt = SHOW;
            end else if (w_turn_exp) begin
               w_expire_turn = 1'b1;
               w_turn_load   = 1'b1;
               w_state_nxt   = PICK1;
            end
         end
         SHOW: begin
            w_show_en = 1'b1;
            if (w_show_exp) begin
               w_state_nxt = JUDGE;
            end
         end
         JUDGE: begin
            w_judge     = 1'b1;
            w_turn_load = 1'b1;
            w_state_nxt = (&w_taken_judged) ? OVER : PICK1;
         end
         OVER: begin
            w_state_nxt = OVER;
         end
         default: begin
            w_state_nxt = PICK1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx1     <= '0;
         r_idx2     <= '0;
         r_lab1     <= '0;
         r_lab2     <= '0;
         r_revealed <= '0;
         r_taken    <= '0;
         r_player   <= 1'b0;
         r_score0   <= '0;
         r_score1   <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_timeout <= w_expire_turn;
         if (w_accept1) begin
            r_idx1               <= bus.cursor;
            r_lab1               <= bus.label;
            r_revealed[bus.cursor] <= 1'b1;
         end
         if (w_accept2) begin
            r_idx2               <= bus.cursor;
            r_lab2               <= bus.label;
            r_revealed[bus.cursor] <= 1'b1;
         end
         if (w_expire_turn) begin
            r_revealed <= '0;
            r_player   <= ~r_player;
         end
         if (w_judge) begin
            r_revealed <= '0;
            r_taken    <= w_taken_judged;
            if (w_match) begin
               if (r_player) begin
                  r_score1 <= r_score1 + SCORE_W_C'(1);
               end else begin
                  r_score0 <= r_score0 + SCORE_W_C'(1);
               end
            end else begin
               r_player <= ~r_player;
            end
         end
      end
   end

   assign bus.revealed  = r_revealed;
   assign bus.taken     = r_taken;
   assign bus.player    = r_player;
   assign bus.score0    = r_score0;
   assign bus.score1    = r_score1;
   assign bus.timeout   = r_timeout;
   assign bus.busy      = (r_state == SHOW) || (r_state == JUDGE);
   assign bus.game_over = (r_state == OVER);
   assign bus.winner    = (r_state == OVER) ? decide_winner(r_score0, r_score1) : WIN_NONE;

endmodule
`default_nettype wire

// File: tb/tb_pair_judge.sv
`default_nettype none
// ============================================================================
// Module : tb_pair_judge
// Randomized turn-level reference model checked against pair_judge.
// Rev    : 1.0
// ============================================================================
module tb_pair_judge;
   localparam int N           = 16;
   localparam int SHOW_CYC    = 4;
   localparam int TIMEOUT_CYC = 20;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [3:0]   deck [N];
   logic [N-1:0] m_taken;
   logic [N-1:0] m_rev;
   logic         m_player;
   int           m_score [2];

   pair_judge_if #(.N_CARDS(N), .LABEL_W(4)) bus ();

   pair_judge #(
      .N_CARDS     (N),
      .LABEL_W     (4),
      .SHOW_CYC    (SHOW_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: observed %0h required %0h", tag, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_sel(input int idx);
      bus.select = 1'b1;
      bus.cursor = 4'(idx);
      bus.label  = deck[idx];
   endtask

   function automatic logic [1:0] exp_winner();
      if (m_taken != '1) return 2'b00;
      if (m_score[0] > m_score[1]) return 2'b01;
      if (m_score[1] > m_score[0]) return 2'b10;
      return 2'b11;
   endfunction

   task automatic model_reset();
      m_taken    = '0;
      m_rev      = '0;
      m_player   = 1'b0;
      m_score[0] = 0;
      m_score[1] = 0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".taken"},    32'(bus.taken),     32'(m_taken));
      check({tag, ".revealed"}, 32'(bus.revealed),  32'(m_rev));
      check({tag, ".player"},   32'(bus.player),    32'(m_player));
      check({tag, ".score0"},   32'(bus.score0),    m_score[0]);
      check({tag, ".score1"},   32'(bus.score1),    m_score[1]);
      check({tag, ".busy"},     32'(bus.busy),      32'd0);
      check({tag, ".game_over"},32'(bus.game_over), 32'((m_taken == '1) ? 1 : 0));
      check({tag, ".winner"},   32'(bus.winner),    32'(exp_winner()));
   endtask

   task automatic do_reset();
      bus.select = 1'b0;
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      model_reset();
   endtask

   task automatic judge_model(input int a, input int b);
      if (deck[a] == deck[b]) begin
         m_taken[a] = 1'b1;
         m_taken[b] = 1'b1;
         m_score[m_player]++;
      end else begin
         m_player = ~m_player;
      end
      m_rev = '0;
   endtask

   task automatic pick(input int idx, input string tag);
      drive_sel(idx);
      tick();
      bus.select = 1'b0;
      m_rev[idx] = 1'b1;
      check({tag, ".rev_first"}, 32'(bus.revealed), 32'(m_rev));
   endtask

   task automatic second_pick(input int a, input int b, input bit noise, input string tag);
      int cnt = 0;
      drive_sel(b);
      tick();
      bus.select = 1'b0;
      m_rev[b] = 1'b1;
      check({tag, ".no_tmo"},     32'(bus.timeout),  32'd0);
      check({tag, ".busy_rise"},  32'(bus.busy),     32'd1);
      check({tag, ".rev_second"}, 32'(bus.revealed), 32'(m_rev));
      while (bus.busy === 1'b1 && cnt < 100) begin
         cnt++;
         check({tag, ".rev_hold"}, 32'(bus.revealed), 32'(m_rev));
         if (noise) drive_sel(int'($urandom_range(0, N - 1)));
         tick();
      end
      bus.select = 1'b0;
      check({tag, ".busy_len"}, cnt, SHOW_CYC + 1);
      judge_model(a, b);
      check_outputs(tag);
   endtask

   task automatic play_turn(input int a, input int b, input bit noise, input string tag);
      pick(a, tag);
      second_pick(a, b, noise, tag);
   endtask

   function automatic int any_taken(input int fallback);
      for (int i = 0; i < N; i++) if (m_taken[i]) return i;
      return fallback;
   endfunction

   task automatic timeout_turn(input int a, input bit noise, input string tag);
      int k = 0;
      pick(a, tag);
      while (k < 100) begin
         if (noise && k < 6) begin
            if (k % 2 == 0) drive_sel(a);
            else            drive_sel(any_taken(a));
         end else begin
            bus.select = 1'b0;
         end
         tick();
         k++;
         if (bus.timeout === 1'b1) break;
         check({tag, ".rev_idle"}, 32'(bus.revealed), 32'(m_rev));
      end
      bus.select = 1'b0;
      check({tag, ".tmo_cycle"}, k, TIMEOUT_CYC);
      check({tag, ".tmo_pulse"}, 32'(bus.timeout), 32'd1);
      m_player = ~m_player;
      m_rev    = '0;
      check_outputs(tag);
      tick();
      check({tag, ".tmo_once"}, 32'(bus.timeout), 32'd0);
   endtask

   task automatic suppress_turn(input int a, input int b, input string tag);
      bit early = 1'b0;
      pick(a, tag);
      repeat (TIMEOUT_CYC - 1) begin
         tick();
         if (bus.timeout === 1'b1) early = 1'b1;
      end
      check({tag, ".tmo_early"}, 32'(early), 32'd0);
      second_pick(a, b, 1'b1, tag);
   endtask

   function automatic int rand_untaken();
      int c = 0;
      for (int t = 0; t < 1000; t++) begin
         c = int'($urandom_range(0, N - 1));
         if (!m_taken[c]) return c;
      end
      return c;
   endfunction

   function automatic int partner(input int a);
      for (int i = 0; i < N; i++)
         if (i != a && !m_taken[i] && deck[i] == deck[a]) return i;
      return a;
   endfunction

   task automatic play_game(input int need0, input int need1, input logic [1:0] exp_w, input string tag);
      int need [2];
      int guard = 0;
      int a, b, p, j;
      logic [3:0] tmp;
      for (int i = 0; i < N; i++) deck[i] = 4'(i / 2);
      for (int i = N - 1; i > 0; i--) begin
         j       = int'($urandom_range(0, i));
         tmp     = deck[i];
         deck[i] = deck[j];
         deck[j] = tmp;
      end
      need[0] = need0;
      need[1] = need1;
      while (m_taken != '1 && guard < 200) begin
         guard++;
         p = int'(m_player);
         if (need[p] > 0 && (need[1 - p] == 0 || $urandom_range(0, 1) == 1)) begin
            a = rand_untaken();
            b = partner(a);
            play_turn(a, b, 1'b0, tag);
            need[p]--;
         end else if ($countones(~m_taken) >= 4 && $urandom_range(0, 3) != 0) begin
            a = rand_untaken();
            b = a;
            for (int t = 0; t < 1000 && (b == a || deck[b] == deck[a]); t++) b = rand_untaken();
            play_turn(a, b, 1'($urandom_range(0, 1)), tag);
         end else begin
            timeout_turn(rand_untaken(), 1'b1, tag);
         end
      end
      check({tag, ".game_over"}, 32'(bus.game_over), 32'd1);
      check({tag, ".winner"},    32'(bus.winner),    32'(exp_w));
      check({tag, ".score0"},    32'(bus.score0),    need0);
      check({tag, ".score1"},    32'(bus.score1),    need1);
      begin
         bit moved = 1'b0;
         repeat (TIMEOUT_CYC + 5) begin
            drive_sel(int'($urandom_range(0, N - 1)));
            tick();
            if (bus.timeout !== 1'b0 || bus.revealed !== '0 || bus.game_over !== 1'b1 ||
                bus.player !== m_player)
               moved = 1'b1;
         end
         bus.select = 1'b0;
         check({tag, ".over_frozen"}, 32'(moved), 32'd0);
      end
   endtask

   initial begin
      int n0;
      logic [1:0] w;
      bus.select = 1'b0;
      bus.cursor = '0;
      bus.label  = '0;
      rst        = 1'b1;
      for (int i = 0; i < N; i++) deck[i] = 4'(i / 2);
      deck[0]  = 4'd1;
      deck[13] = 4'd1;
      deck[1]  = 4'd3;
      model_reset();
      #2 rst = 1'b0;
      #1;
      check_outputs("reset");
      check("reset.timeout", 32'(bus.timeout), 32'd0);
      tick();
      tick();
      rst = 1'b1;

      play_turn(0, 13, 1'b0, "match");
      check("match.taken_const",  32'(bus.taken),  32'h2001);
      check("match.score0_const", 32'(bus.score0), 32'd1);
      check("match.player_const", 32'(bus.player), 32'd0);

      timeout_turn(2, 1'b1, "timeout");
      check("timeout.player_const", 32'(bus.player), 32'd1);

      suppress_turn(3, 4, "suppress");

      do_reset();
      check_outputs("reset2");
      play_turn(0, 1, 1'b0, "mismatch");
      check("mismatch.player_const", 32'(bus.player), 32'd1);
      check("mismatch.taken_const",  32'(bus.taken),  32'd0);

      deck[2] = 4'd5;
      deck[3] = 4'd5;
      play_turn(2, 3, 1'b0, "pre_rst");
      pick(4, "rst_show");
      drive_sel(5);
      tick();
      bus.select = 1'b0;
      check("rst_show.busy", 32'(bus.busy), 32'd1);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_outputs("async_rst");
      check("async_rst.timeout", 32'(bus.timeout), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      play_turn(6, 7, 1'b0, "post_rst");

      do_reset();
      play_game(5, 3, 2'b01, "game53");
      do_reset();
      play_game(4, 4, 2'b11, "game44");
      do_reset();
      n0 = int'($urandom_range(0, 8));
      w  = (n0 > 4) ? 2'b01 : ((n0 < 4) ? 2'b10 : 2'b11);
      play_game(n0, 8 - n0, w, "game_rand");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
